ram_moc_controller: RTL and testbench

- Data-memory interface that consumes the control unit's memory-request signals (MOV, RW, data type) and produces the MOC (memory operation complete) status that the control unit's condition mux tests.
- Byte-addressed, big-endian RAM with a programmable access latency.
- Sits directly downstream of the control register: MAR feeds the address, MDR feeds write data, and read data returns to MDR.

---
 rtl/ram_moc_controller_pkg.sv | 36 +++
 rtl/ram_byte_array.sv | 37 +++
 rtl/ram_moc_controller.sv | 156 +++++++++++++++
 tb/tb_ram_moc_controller.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/ram_moc_controller_pkg.sv
// Shared encodings and lane helpers for the MOC-handshake data memory.
package ram_moc_controller_pkg;

    localparam logic [1:0] TYPE_BYTE = 2'b00;
    localparam logic [1:0] TYPE_HALF = 2'b01;
    localparam logic [1:0] TYPE_WORD = 2'b10;

    localparam logic RW_READ = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Reserved type 2'b11 behaves as a word everywhere.
    function automatic logic is_misaligned(input logic [1:0] ty, input logic [1:0] a);
        if (ty == TYPE_BYTE)      return 1'b0;
        else if (ty == TYPE_HALF) return a[0];
        else                      return (a != 2'b00);
    endfunction

    // Lane k addresses byte a+k; lane 0 is the most significant byte.
    function automatic logic [3:0] lane_mask(input logic [1:0] ty);
        if (ty == TYPE_BYTE)      return 4'b0001;
        else if (ty == TYPE_HALF) return 4'b0011;
        else                      return 4'b1111;
    endfunction

    function automatic logic [31:0] wr_align(input logic [1:0] ty, input logic [31:0] d);
        if (ty == TYPE_BYTE)      return {d[7:0], 24'h0};
        else if (ty == TYPE_HALF) return {d[15:0], 16'h0};
        else                      return d;
    endfunction

endpackage

// File: rtl/ram_byte_array.sv
// Byte memory with four consecutive byte lanes at a..a+3, synchronous write, combinational read.
module ram_byte_array #(
    parameter int unsigned ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [3:0]            we_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [7:0]            mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] lane_addr [4];

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            lane_addr[k] = addr_i + ADDR_WIDTH'(k);
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (we_i[k]) begin
                mem_q[lane_addr[k]] <= wdata_i[31-8*k -: 8];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            rdata_o[31-8*k -: 8] = mem_q[lane_addr[k]];
        end
    end

endmodule

// File: rtl/ram_moc_controller.sv
// Big-endian data memory behind MAR/MDR with programmable latency and a
// four-phase MOV/MOC handshake toward the control unit.
module ram_moc_controller
    import ram_moc_controller_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 9,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MOV,
    input  logic        RW,
    input  logic [1:0]  Type,
    input  logic        SE,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        MOC,
    output logic        AddrErr
);

    localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            type_q, type_d;
    logic                  rw_q, rw_d;
    logic                  se_q, se_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  moc_q, moc_d;
    logic                  err_q, err_d;
    logic [31:0]           dout_q, dout_d;

    logic                  misaligned_c;
    logic                  access_c;
    logic [3:0]            mem_we_c;
    logic [31:0]           mem_rdata_c;
    logic [31:0]           read_ext_c;
    logic                  unused_addr_c;

    // Upper address bits are deliberately dropped so accesses wrap.
    assign unused_addr_c = ^Address[31:ADDR_WIDTH];

    assign misaligned_c = is_misaligned(Type, Address[1:0]);
    assign access_c     = (state_q == BUSY) && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (MOV) state_d = misaligned_c ? DONE : BUSY;
            BUSY:    if (access_c) state_d = DONE;
            DONE:    if (!MOV) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture, latency count, memory strobes and registered outputs.
    always_comb begin
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        type_d   = type_q;
        rw_d     = rw_q;
        se_d     = se_q;
        wdata_d  = wdata_q;
        moc_d    = moc_q;
        err_d    = err_q;
        dout_d   = dout_q;
        mem_we_c = '0;
        case (state_q)
            IDLE: begin
                if (MOV) begin
                    addr_d  = Address[ADDR_WIDTH-1:0];
                    type_d  = Type;
                    rw_d    = RW;
                    se_d    = SE;
                    wdata_d = DataIn;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    if (misaligned_c) begin
                        moc_d = 1'b1;
                        err_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (!access_c) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    moc_d = 1'b1;
                    err_d = 1'b0;
                    if (rw_q == RW_READ) dout_d   = read_ext_c;
                    else if (!reset)     mem_we_c = lane_mask(type_q);
                end
            end
            DONE: begin
                if (!MOV) begin
                    moc_d = 1'b0;
                    err_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        case (type_q)
            TYPE_BYTE: read_ext_c = {{24{se_q & mem_rdata_c[31]}}, mem_rdata_c[31:24]};
            TYPE_HALF: read_ext_c = {{16{se_q & mem_rdata_c[31]}}, mem_rdata_c[31:16]};
            default:   read_ext_c = mem_rdata_c;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            addr_q  <= '0;
            type_q  <= TYPE_BYTE;
            rw_q    <= 1'b0;
            se_q    <= 1'b0;
            wdata_q <= '0;
            moc_q   <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            type_q  <= type_d;
            rw_q    <= rw_d;
            se_q    <= se_d;
            wdata_q <= wdata_d;
            moc_q   <= moc_d;
            err_q   <= err_d;
            dout_q  <= dout_d;
        end
    end

    ram_byte_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .addr_i  (addr_q),
        .we_i    (mem_we_c),
        .wdata_i (wr_align(type_q, wdata_q)),
        .rdata_o (mem_rdata_c)
    );

    assign DataOut = dout_q;
    assign MOC     = moc_q;
    assign AddrErr = err_q;

endmodule

// File: tb/tb_ram_moc_controller.sv
// Scoreboard bench for ram_moc_controller: directed requests push expectations, a monitor checks each MOC rise.
module tb_ram_moc_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        MOV;
    logic        RW;
    logic [1:0]  Type;
    logic        SE;
    logic [31:0] Address;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        MOC;
    logic        AddrErr;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;
    logic moc_prev = 1'b0;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          lat;
        int          issue;
    } exp_t;

    exp_t sb_q[$];

    ram_moc_controller #(
        .ADDR_WIDTH  (9),
        .WAIT_CYCLES (2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .MOV     (MOV),
        .RW      (RW),
        .Type    (Type),
        .SE      (SE),
        .Address (Address),
        .DataIn  (DataIn),
        .DataOut (DataOut),
        .MOC     (MOC),
        .AddrErr (AddrErr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Monitor: every MOC rise must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (MOC === 1'b1 && !moc_prev) begin
            if (sb_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_moc: got MOC=1 expected no completion (DataOut=0x%08h)", DataOut);
            end else begin
                e = sb_q.pop_front();
                check("dataout", DataOut, e.d);
                check("addrerr", 32'(AddrErr), 32'(e.e));
                check("latency", 32'(cyc - e.issue), 32'(e.lat));
            end
        end
        moc_prev = (MOC === 1'b1);
    end

    task automatic req(input logic rw, input logic [1:0] ty, input logic se,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic [31:0] exp_d, input logic exp_e, input int hold);
        exp_t e;
        bit   got;
        @(negedge clk);
        MOV = 1'b1; RW = rw; Type = ty; SE = se; Address = addr; DataIn = data;
        e.d = exp_d; e.e = exp_e; e.lat = exp_e ? 0 : 3; e.issue = cyc + 1;
        sb_q.push_back(e);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (MOC === 1'b1) begin
                got = 1'b1;
                break;
            end
            Address = addr ^ 32'h0000_0044; DataIn = ~data; Type = ~ty; SE = ~se; RW = ~rw;
        end
        check("moc_seen", 32'(got), 32'd1);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("moc_hold", 32'(MOC), 32'd1);
            check("hold_data", DataOut, exp_d);
        end
        MOV = 1'b0;
        @(negedge clk);
        check("moc_release", 32'(MOC), 32'd0);
        check("err_release", 32'(AddrErr), 32'd0);
    endtask

    initial begin
        reset = 1'b1; MOV = 1'b0; RW = 1'b0; Type = 2'b00; SE = 1'b0;
        Address = '0; DataIn = '0;
        repeat (2) @(negedge clk);
        check("rst_moc", 32'(MOC), 32'd0);
        check("rst_err", 32'(AddrErr), 32'd0);
        check("rst_dout", DataOut, 32'h0);
        reset = 1'b0;

        // rw, type, se, addr, data, expected DataOut, expected AddrErr, hold
        req(1'b0, 2'b10, 1'b0, 32'h010, 32'h12345678, 32'h00000000, 1'b0, 0);
        req(1'b1, 2'b10, 1'b1, 32'h010, 32'h0,        32'h12345678, 1'b0, 0);
        req(1'b1, 2'b00, 1'b0, 32'h011, 32'h0,        32'h00000034, 1'b0, 0);
        req(1'b0, 2'b00, 1'b0, 32'h020, 32'h00000080, 32'h00000034, 1'b0, 0);
        req(1'b1, 2'b00, 1'b1, 32'h020, 32'h0,        32'hFFFFFF80, 1'b0, 0);
        req(1'b1, 2'b00, 1'b0, 32'h020, 32'h0,        32'h00000080, 1'b0, 0);
        req(1'b0, 2'b01, 1'b0, 32'h022, 32'h00008001, 32'h00000080, 1'b0, 0);
        req(1'b1, 2'b01, 1'b1, 32'h022, 32'h0,        32'hFFFF8001, 1'b0, 0);
        req(1'b0, 2'b10, 1'b0, 32'h000, 32'hA5A5A5A5, 32'hFFFF8001, 1'b0, 0);
        req(1'b0, 2'b01, 1'b0, 32'h001, 32'h0000BEEF, 32'hFFFF8001, 1'b1, 0);
        req(1'b1, 2'b10, 1'b1, 32'h000, 32'h0,        32'hA5A5A5A5, 1'b0, 0);
        req(1'b1, 2'b10, 1'b1, 32'h010, 32'h0,        32'h12345678, 1'b0, 5);
        req(1'b1, 2'b10, 1'b1, 32'h002, 32'h0,        32'h12345678, 1'b1, 0);
        req(1'b0, 2'b10, 1'b0, 32'h040, 32'h11223344, 32'h12345678, 1'b0, 0);

        // Reset during the first BUSY cycle of a write.
        @(negedge clk);
        MOV = 1'b1; RW = 1'b0; Type = 2'b10; SE = 1'b0; Address = 32'h040; DataIn = 32'hDEADBEEF;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; MOV = 1'b0;
        check("abort_moc", 32'(MOC), 32'd0);
        check("abort_dout", DataOut, 32'h0);
        check("abort_err", 32'(AddrErr), 32'd0);
        repeat (4) @(negedge clk);
        check("abort_quiet", 32'(MOC), 32'd0);

        req(1'b1, 2'b10, 1'b1, 32'h040, 32'h0,        32'h11223344, 1'b0, 0);
        req(1'b0, 2'b10, 1'b0, 32'h204, 32'hCAFEF00D, 32'h11223344, 1'b0, 0);
        req(1'b1, 2'b10, 1'b1, 32'h004, 32'h0,        32'hCAFEF00D, 1'b0, 0);
        req(1'b1, 2'b01, 1'b1, 32'h206, 32'h0,        32'hFFFFF00D, 1'b0, 0);
        req(1'b0, 2'b10, 1'b0, 32'h1FC, 32'h01020304, 32'hFFFFF00D, 1'b0, 0);
        req(1'b1, 2'b00, 1'b1, 32'h1FF, 32'h0,        32'h00000004, 1'b0, 0);
        req(1'b1, 2'b11, 1'b0, 32'h1FC, 32'h0,        32'h01020304, 1'b0, 0);

        // MOV raised together with reset must not be captured.
        @(negedge clk);
        reset = 1'b1; MOV = 1'b1; RW = 1'b1; Type = 2'b10; Address = 32'h010;
        @(negedge clk);
        reset = 1'b0; MOV = 1'b0;
        repeat (5) @(negedge clk);
        check("rstmov_moc", 32'(MOC), 32'd0);
        check("rstmov_dout", DataOut, 32'h0);

        req(1'b1, 2'b10, 1'b1, 32'h010, 32'h0,        32'h12345678, 1'b0, 0);

        @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
